// File: rtl/execute_out_wb_pkg.sv
// Shared types, writeback-source encodings, opcode constants and NZP helper
// for the execute_out writeback responder.
package execute_out_wb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_e;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_PC  = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_LEA = 4'b1110;

  function automatic logic is_wb_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR, OP_LDI, OP_LEA};
  endfunction

  // {N,Z,P}: exactly one bit set for any value.
  function automatic logic [2:0] calc_nzp(input logic signed [15:0] value);
    logic n;
    logic z;
    n = (value < 0);
    z = (value == '0);
    return {n, z, !n && !z};
  endfunction

endpackage

// File: rtl/lc3_regfile.sv
// LC-3 register file: one write port, two combinational read ports.
// Define WB_BYPASS_EN to forward same-cycle write data to the read ports.
module lc3_regfile
  import execute_out_wb_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic        [ADDR_W-1:0] waddr_i,
  input  logic signed [DATA_W-1:0] wdata_i,
  input  logic        [ADDR_W-1:0] raddr1_i,
  input  logic        [ADDR_W-1:0] raddr2_i,
  output logic signed [DATA_W-1:0] rdata1_o,
  output logic signed [DATA_W-1:0] rdata2_o
);

  logic signed [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

`ifdef WB_BYPASS_EN
  assign rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : regs_q[raddr2_i];
`else
  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];
`endif

endmodule

// File: rtl/execute_out_wb_responder.sv
// Retires execute_out transactions into the LC-3 register file and PSR,
// waiting for load data when needed. Optional macro: WB_BYPASS_EN (read forwarding).
module execute_out_wb_responder
  import execute_out_wb_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 8,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en_ex,
  input  logic                     en_writeback,
  input  logic        [1:0]        W_Control_out,
  input  logic                     Mem_Control_out,
  input  logic signed [DATA_W-1:0] aluout,
  input  logic signed [DATA_W-1:0] pcout,
  input  logic        [2:0]        dr,
  input  logic        [2:0]        sr1,
  input  logic        [2:0]        sr2,
  input  logic        [15:0]       IR_Exec,
  input  logic        [2:0]        NZP,
  input  logic        [DATA_W-1:0] M_data,
  input  logic signed [DATA_W-1:0] memout,
  input  logic                     mem_rdy,
  output logic signed [DATA_W-1:0] VSR1,
  output logic signed [DATA_W-1:0] VSR2,
  output logic        [2:0]        psr,
  output logic                     wb_busy,
  output logic                     mem_mode,
  output logic                     wb_done,
  output logic                     protocol_err
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  wb_state_e                state_q, state_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic        [2:0]        psr_q, psr_d;
  logic                     done_q, done_d;
  logic                     perr_q, perr_d;
  logic                     mem_mode_q;

  logic        [1:0]        wctl_q;
  logic        [2:0]        dr_q;
  logic        [3:0]        op_q;
  logic        [2:0]        nzp_q;
  logic signed [DATA_W-1:0] alu_q, pc_q, mem_q;

  logic                     capture;
  logic                     timeout;
  logic                     wr_en;
  logic signed [DATA_W-1:0] wr_val;
  logic                     unused_bits;

  assign capture = en_ex && en_writeback && (state_q != WAIT_MEM);
  assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) && !mem_rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    psr_d   = psr_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    wr_en   = 1'b0;
    wr_val  = alu_q;
    unique case (state_q)
      WAIT_MEM: begin
        // A new transaction while a load is outstanding is dropped, not queued.
        if (en_ex && en_writeback) perr_d = 1'b1;
        if (mem_rdy) begin
          state_d = WRITE;
        end else if (timeout) begin
          state_d = IDLE;
          perr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        unique case (wctl_q)
          WB_PC:   wr_val = pc_q;
          WB_MEM:  wr_val = mem_q;
          default: wr_val = alu_q;
        endcase
        if (is_wb_op(op_q)) begin
          if (wctl_q == 2'd3) begin
            perr_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            psr_d = calc_nzp(wr_val);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A same-cycle capture overrides the default return to IDLE.
    if (capture) begin
      cnt_d   = '0;
      state_d = ((W_Control_out == WB_MEM) && is_wb_op(IR_Exec[15:12])) ? WAIT_MEM : WRITE;
    end
  end

  // ---- control registers ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      psr_q      <= 3'b010;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      mem_mode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      psr_q   <= psr_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      if (capture) mem_mode_q <= Mem_Control_out;
    end
  end

  // ---- captured transaction data ----
  always_ff @(posedge clock) begin
    if (capture) begin
      wctl_q <= W_Control_out;
      dr_q   <= dr;
      op_q   <= IR_Exec[15:12];
      nzp_q  <= NZP;
      alu_q  <= aluout;
      pc_q   <= pcout;
    end
    if ((state_q == WAIT_MEM) && mem_rdy) mem_q <= memout;
  end

  lc3_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk_i    (clock),
    .rst_i    (reset),
    .we_i     (wr_en),
    .waddr_i  (dr_q),
    .wdata_i  (wr_val),
    .raddr1_i (sr1),
    .raddr2_i (sr2),
    .rdata1_o (VSR1),
    .rdata2_o (VSR2)
  );

  assign psr          = psr_q;
  assign wb_busy      = (state_q == WAIT_MEM);
  assign mem_mode     = mem_mode_q;
  assign wb_done      = done_q;
  assign protocol_err = perr_q;

  // Store data, the branch field and the low IR bits are not used by writeback.
  assign unused_bits = ^{M_data, nzp_q, IR_Exec[11:0]};

endmodule

// File: tb/tb_execute_out_wb_responder.sv
// Self-checking bench for execute_out_wb_responder: directed scenarios plus
// randomized transactions against a transaction-level reference model.
module tb_execute_out_wb_responder;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset, en_ex, en_writeback, Mem_Control_out, mem_rdy;
  logic [1:0]  W_Control_out;
  logic [15:0] aluout, pcout, IR_Exec, M_data, memout;
  logic [2:0]  dr, sr1, sr2, NZP;
  logic [15:0] VSR1, VSR2;
  logic [2:0]  psr;
  logic        wb_busy, mem_mode, wb_done, protocol_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] mreg [8];
  logic [2:0]  mpsr;

  execute_out_wb_responder #(
    .DATA_W(16), .NUM_REGS(8), .MEM_TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset), .en_ex(en_ex), .en_writeback(en_writeback),
    .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out),
    .aluout(aluout), .pcout(pcout), .dr(dr), .sr1(sr1), .sr2(sr2),
    .IR_Exec(IR_Exec), .NZP(NZP), .M_data(M_data), .memout(memout), .mem_rdy(mem_rdy),
    .VSR1(VSR1), .VSR2(VSR2), .psr(psr), .wb_busy(wb_busy), .mem_mode(mem_mode),
    .wb_done(wb_done), .protocol_err(protocol_err)
  );

  always #10 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached (tests_run=%0d)", tests_run);
    $fatal(1, "watchdog");
  end

  function automatic bit qual(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h5) || (op == 4'h9) || (op == 4'h2) ||
           (op == 4'h6) || (op == 4'hA) || (op == 4'hE);
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15]) return 3'b100;
    else if (v == 16'h0) return 3'b010;
    else return 3'b001;
  endfunction

  task automatic idle_inputs();
    en_ex = 1'b0; en_writeback = 1'b1; W_Control_out = 2'd0; Mem_Control_out = 1'b0;
    aluout = 16'h0; pcout = 16'h0; IR_Exec = 16'h0; M_data = 16'h0; memout = 16'h0;
    mem_rdy = 1'b0; dr = 3'd0; sr1 = 3'd0; sr2 = 3'd0; NZP = 3'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
    mpsr = 3'b010;
  endtask

  task automatic drive(input logic [15:0] ir, input logic [1:0] wc, input logic [2:0] d,
                       input logic [15:0] a, input logic [15:0] p, input logic mm);
    en_ex = 1'b1; IR_Exec = ir; W_Control_out = wc; dr = d; aluout = a; pcout = p;
    Mem_Control_out = mm; NZP = ir[11:9]; M_data = 16'($urandom);
  endtask

  task automatic send(input logic [15:0] ir, input logic [1:0] wc, input logic [2:0] d,
                      input logic [15:0] a, input logic [15:0] p, input logic mm);
    drive(ir, wc, d, a, p, mm);
    @(posedge clock); #1;
    en_ex = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    send(16'h1E3F, 2'd0, 3'd7, 16'h4321, 16'h0, 1'b1);
    @(posedge clock); #1;
    do_reset();
    tests_run++; if (psr !== 3'b010) begin tests_failed++; $display("FAIL reset_psr got %b exp 010", psr); end
    tests_run++; if (wb_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", wb_busy); end
    tests_run++; if (wb_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", wb_done); end
    tests_run++; if (protocol_err !== 1'b0) begin tests_failed++; $display("FAIL reset_perr got %b exp 0", protocol_err); end
    tests_run++; if (mem_mode !== 1'b0) begin tests_failed++; $display("FAIL reset_memmode got %b exp 0", mem_mode); end
    for (int r = 0; r < 8; r++) begin
      sr1 = 3'(r); sr2 = 3'(7 - r); #1;
      tests_run++; if (VSR1 !== 16'h0) begin tests_failed++; $display("FAIL reset_vsr1 r%0d got %h exp 0000", r, VSR1); end
      tests_run++; if (VSR2 !== 16'h0) begin tests_failed++; $display("FAIL reset_vsr2 r%0d got %h exp 0000", 7 - r, VSR2); end
    end
  endtask

  task automatic test_add();
    do_reset();
    send(16'h1261, 2'd0, 3'd1, 16'h8000, 16'h0, 1'b0);
    tests_run++; if (wb_done !== 1'b0) begin tests_failed++; $display("FAIL add_done_early got %b exp 0", wb_done); end
    @(posedge clock); #1;
    sr1 = 3'd1; #1;
    tests_run++; if (VSR1 !== 16'h8000) begin tests_failed++; $display("FAIL add_r1 got %h exp 8000", VSR1); end
    tests_run++; if (psr !== 3'b100) begin tests_failed++; $display("FAIL add_psr got %b exp 100", psr); end
    tests_run++; if (wb_done !== 1'b1) begin tests_failed++; $display("FAIL add_done got %b exp 1", wb_done); end
    @(posedge clock); #1;
    tests_run++; if (wb_done !== 1'b0) begin tests_failed++; $display("FAIL add_done_pulse got %b exp 0", wb_done); end
  endtask

  task automatic test_load();
    do_reset();
    send(16'h14A1, 2'd0, 3'd2, 16'h1234, 16'h0, 1'b0);
    @(posedge clock); #1;
    send(16'h2405, 2'd2, 3'd2, 16'h7777, 16'h6666, 1'b1);
    tests_run++; if (mem_mode !== 1'b1) begin tests_failed++; $display("FAIL ld_memmode got %b exp 1", mem_mode); end
    for (int c = 1; c <= 3; c++) begin
      tests_run++; if (wb_busy !== 1'b1) begin tests_failed++; $display("FAIL ld_busy c%0d got %b exp 1", c, wb_busy); end
      if (c == 3) begin mem_rdy = 1'b1; memout = 16'h0000; end
      @(posedge clock); #1;
      mem_rdy = 1'b0; memout = 16'hFFFF;
    end
    tests_run++; if (wb_busy !== 1'b0) begin tests_failed++; $display("FAIL ld_busy_end got %b exp 0", wb_busy); end
    @(posedge clock); #1;
    sr2 = 3'd2; #1;
    tests_run++; if (VSR2 !== 16'h0000) begin tests_failed++; $display("FAIL ld_r2 got %h exp 0000", VSR2); end
    tests_run++; if (psr !== 3'b010) begin tests_failed++; $display("FAIL ld_psr got %b exp 010", psr); end
    tests_run++; if (wb_done !== 1'b1) begin tests_failed++; $display("FAIL ld_done got %b exp 1", wb_done); end
  endtask

  task automatic test_timeout();
    int busy_n, perr_n, done_n, perr_at;
    do_reset();
    send(16'h1A21, 2'd0, 3'd5, 16'h0777, 16'h0, 1'b0);
    @(posedge clock); #1;
    send(16'h6A40, 2'd2, 3'd5, 16'h1111, 16'h2222, 1'b0);
    busy_n = 0; perr_n = 0; done_n = 0; perr_at = -1;
    for (int c = 0; c < 12; c++) begin
      if (wb_busy) busy_n++;
      @(posedge clock); #1;
      if (protocol_err) begin perr_n++; perr_at = c; end
      if (wb_done) done_n++;
    end
    sr1 = 3'd5; #1;
    tests_run++; if (busy_n !== TMO) begin tests_failed++; $display("FAIL tmo_busy_cycles got %0d exp %0d", busy_n, TMO); end
    tests_run++; if (perr_n !== 1) begin tests_failed++; $display("FAIL tmo_perr_count got %0d exp 1", perr_n); end
    tests_run++; if (perr_at !== TMO - 1) begin tests_failed++; $display("FAIL tmo_perr_cycle got %0d exp %0d", perr_at, TMO - 1); end
    tests_run++; if (done_n !== 0) begin tests_failed++; $display("FAIL tmo_done got %0d exp 0", done_n); end
    tests_run++; if (VSR1 !== 16'h0777) begin tests_failed++; $display("FAIL tmo_r5 got %h exp 0777", VSR1); end
    tests_run++; if (psr !== 3'b001) begin tests_failed++; $display("FAIL tmo_psr got %b exp 001", psr); end
  endtask

  task automatic test_drop();
    do_reset();
    send(16'h2800, 2'd2, 3'd4, 16'h0, 16'h0, 1'b0);
    drive(16'h1C21, 2'd0, 3'd6, 16'h5555, 16'h0, 1'b1);
    @(posedge clock); #1;
    en_ex = 1'b0;
    tests_run++; if (protocol_err !== 1'b1) begin tests_failed++; $display("FAIL drop_perr got %b exp 1", protocol_err); end
    tests_run++; if (wb_busy !== 1'b1) begin tests_failed++; $display("FAIL drop_busy got %b exp 1", wb_busy); end
    tests_run++; if (mem_mode !== 1'b0) begin tests_failed++; $display("FAIL drop_memmode got %b exp 0", mem_mode); end
    mem_rdy = 1'b1; memout = 16'hC0DE;
    @(posedge clock); #1;
    mem_rdy = 1'b0;
    tests_run++; if (protocol_err !== 1'b0) begin tests_failed++; $display("FAIL drop_perr_pulse got %b exp 0", protocol_err); end
    @(posedge clock); #1;
    sr1 = 3'd4; sr2 = 3'd6; #1;
    tests_run++; if (wb_done !== 1'b1) begin tests_failed++; $display("FAIL drop_done got %b exp 1", wb_done); end
    tests_run++; if (VSR1 !== 16'hC0DE) begin tests_failed++; $display("FAIL drop_r4 got %h exp c0de", VSR1); end
    tests_run++; if (VSR2 !== 16'h0000) begin tests_failed++; $display("FAIL drop_r6 got %h exp 0000", VSR2); end
    tests_run++; if (psr !== 3'b100) begin tests_failed++; $display("FAIL drop_psr got %b exp 100", psr); end
  endtask

  task automatic test_nowrite_ops();
    do_reset();
    send(16'h1261, 2'd3, 3'd1, 16'h0001, 16'h0, 1'b0);
    @(posedge clock); #1;
    sr1 = 3'd1; #1;
    tests_run++; if (wb_done !== 1'b1) begin tests_failed++; $display("FAIL w3_done got %b exp 1", wb_done); end
    tests_run++; if (protocol_err !== 1'b1) begin tests_failed++; $display("FAIL w3_perr got %b exp 1", protocol_err); end
    tests_run++; if (VSR1 !== 16'h0) begin tests_failed++; $display("FAIL w3_r1 got %h exp 0000", VSR1); end
    send(16'h0E05, 2'd2, 3'd7, 16'h0007, 16'h0, 1'b0);
    tests_run++; if (wb_busy !== 1'b0) begin tests_failed++; $display("FAIL br_busy got %b exp 0", wb_busy); end
    @(posedge clock); #1;
    sr2 = 3'd7; #1;
    tests_run++; if (wb_done !== 1'b1) begin tests_failed++; $display("FAIL br_done got %b exp 1", wb_done); end
    tests_run++; if (protocol_err !== 1'b0) begin tests_failed++; $display("FAIL br_perr got %b exp 0", protocol_err); end
    tests_run++; if (VSR2 !== 16'h0) begin tests_failed++; $display("FAIL br_r7 got %h exp 0000", VSR2); end
    tests_run++; if (psr !== 3'b010) begin tests_failed++; $display("FAIL nowrite_psr got %b exp 010", psr); end
  endtask

  task automatic test_en_writeback();
    do_reset();
    en_writeback = 1'b0;
    send(16'h1261, 2'd0, 3'd1, 16'h0042, 16'h0, 1'b1);
    @(posedge clock); #1;
    sr1 = 3'd1; #1;
    tests_run++; if (wb_done !== 1'b0) begin tests_failed++; $display("FAIL enwb_done got %b exp 0", wb_done); end
    tests_run++; if (VSR1 !== 16'h0) begin tests_failed++; $display("FAIL enwb_r1 got %h exp 0000", VSR1); end
    tests_run++; if (mem_mode !== 1'b0) begin tests_failed++; $display("FAIL enwb_memmode got %b exp 0", mem_mode); end
    en_writeback = 1'b1;
    send(16'hA600, 2'd2, 3'd3, 16'h0, 16'h0, 1'b0);
    en_writeback = 1'b0;
    drive(16'h1261, 2'd0, 3'd1, 16'h0099, 16'h0, 1'b0);
    @(posedge clock); #1;
    en_ex = 1'b0;
    tests_run++; if (protocol_err !== 1'b0) begin tests_failed++; $display("FAIL enwb_silent got %b exp 0", protocol_err); end
    mem_rdy = 1'b1; memout = 16'h0123;
    @(posedge clock); #1;
    mem_rdy = 1'b0;
    @(posedge clock); #1;
    sr1 = 3'd3; sr2 = 3'd1; #1;
    tests_run++; if (VSR1 !== 16'h0123) begin tests_failed++; $display("FAIL enwb_r3 got %h exp 0123", VSR1); end
    tests_run++; if (VSR2 !== 16'h0) begin tests_failed++; $display("FAIL enwb_r1_late got %h exp 0000", VSR2); end
    en_writeback = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(16'h3000, 2'd0, 3'd0, 16'hBEEF, 16'h0, 1'b0);
    @(posedge clock); #1;
    drive(16'hE3FF, 2'd1, 3'd1, 16'h00AB, 16'h3010, 1'b0);
    @(posedge clock); #1;
    en_ex = 1'b0;
    tests_run++; if (wb_done !== 1'b1) begin tests_failed++; $display("FAIL b2b_done_st got %b exp 1", wb_done); end
    tests_run++; if (psr !== 3'b010) begin tests_failed++; $display("FAIL b2b_psr_st got %b exp 010", psr); end
    @(posedge clock); #1;
    sr1 = 3'd1; sr2 = 3'd0; #1;
    tests_run++; if (wb_done !== 1'b1) begin tests_failed++; $display("FAIL b2b_done_lea got %b exp 1", wb_done); end
    tests_run++; if (VSR1 !== 16'h3010) begin tests_failed++; $display("FAIL b2b_r1 got %h exp 3010", VSR1); end
    tests_run++; if (VSR2 !== 16'h0) begin tests_failed++; $display("FAIL b2b_r0 got %h exp 0000", VSR2); end
    tests_run++; if (psr !== 3'b001) begin tests_failed++; $display("FAIL b2b_psr got %b exp 001", psr); end
    @(posedge clock); #1;
    tests_run++; if (wb_done !== 1'b0) begin tests_failed++; $display("FAIL b2b_done_end got %b exp 0", wb_done); end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_fwd;
`ifdef WB_BYPASS_EN
    exp_fwd = 16'h00AA;
`else
    exp_fwd = 16'h0000;
`endif
    do_reset();
    send(16'h16E1, 2'd0, 3'd3, 16'h00AA, 16'h0, 1'b0);
    sr1 = 3'd3; #1;
    tests_run++; if (VSR1 !== exp_fwd) begin tests_failed++; $display("FAIL bypass_same_cycle got %h exp %h", VSR1, exp_fwd); end
    @(posedge clock); #1;
    tests_run++; if (VSR1 !== 16'h00AA) begin tests_failed++; $display("FAIL bypass_next_cycle got %h exp 00aa", VSR1); end
  endtask

  task automatic test_reset_midwait();
    do_reset();
    send(16'h1261, 2'd0, 3'd1, 16'h0055, 16'h0, 1'b0);
    @(posedge clock); #1;
    send(16'h2200, 2'd2, 3'd1, 16'h0, 16'h0, 1'b1);
    reset = 1'b1; mem_rdy = 1'b1; memout = 16'h1234;
    @(posedge clock); #1;
    reset = 1'b0;
    tests_run++; if (wb_busy !== 1'b0) begin tests_failed++; $display("FAIL rstw_busy got %b exp 0", wb_busy); end
    tests_run++; if (mem_mode !== 1'b0) begin tests_failed++; $display("FAIL rstw_memmode got %b exp 0", mem_mode); end
    tests_run++; if (psr !== 3'b010) begin tests_failed++; $display("FAIL rstw_psr got %b exp 010", psr); end
    @(posedge clock); #1;
    mem_rdy = 1'b0;
    @(posedge clock); #1;
    sr1 = 3'd1; #1;
    tests_run++; if (wb_done !== 1'b0) begin tests_failed++; $display("FAIL rstw_done got %b exp 0", wb_done); end
    tests_run++; if (VSR1 !== 16'h0) begin tests_failed++; $display("FAIL rstw_r1 got %h exp 0000", VSR1); end
  endtask

  task automatic test_random();
    logic [3:0]  ops [10];
    logic [3:0]  op;
    logic [1:0]  wc;
    logic [2:0]  d;
    logic [15:0] a, p, mv, v;
    logic        mm;
    int          k, exp_busy, exp_done, exp_perr, busy_n, done_n, perr_n;
    bit          waits, writes;
    ops = '{4'h1, 4'h5, 4'h9, 4'h2, 4'h6, 4'hA, 4'hE, 4'h0, 4'h3, 4'h7};
    do_reset();
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 9)];
      wc = 2'($urandom_range(0, 3));
      d  = 3'($urandom_range(0, 7));
      a  = 16'($urandom); p = 16'($urandom); mv = 16'($urandom);
      mm = 1'($urandom_range(0, 1));
      k  = $urandom_range(1, 6);
      // Expected outcome of one transaction, straight from the retirement rules.
      waits    = qual(op) && (wc == 2'd2);
      exp_busy = waits ? ((k <= TMO) ? k : TMO) : 0;
      exp_done = (waits && k > TMO) ? 0 : 1;
      exp_perr = (qual(op) && (wc == 2'd3 || (waits && k > TMO))) ? 1 : 0;
      writes   = qual(op) && (wc != 2'd3) && !(waits && k > TMO);
      v = (wc == 2'd0) ? a : (wc == 2'd1) ? p : mv;
      if (writes) begin mreg[d] = v; mpsr = nzp_of(v); end

      send({op, d, 9'($urandom)}, wc, d, a, p, mm);
      tests_run++; if (mem_mode !== mm) begin tests_failed++; $display("FAIL rnd_memmode n%0d got %b exp %b", n, mem_mode, mm); end
      busy_n = 0; done_n = 0; perr_n = 0;
      for (int c = 1; c <= 8; c++) begin
        if (wb_busy) busy_n++;
        mem_rdy = (c == k); memout = mv;
        @(posedge clock); #1;
        mem_rdy = 1'b0; memout = 16'($urandom);
        if (wb_done) done_n++;
        if (protocol_err) perr_n++;
      end
      tests_run++; if (busy_n !== exp_busy) begin tests_failed++; $display("FAIL rnd_busy n%0d got %0d exp %0d", n, busy_n, exp_busy); end
      tests_run++; if (done_n !== exp_done) begin tests_failed++; $display("FAIL rnd_done n%0d got %0d exp %0d", n, done_n, exp_done); end
      tests_run++; if (perr_n !== exp_perr) begin tests_failed++; $display("FAIL rnd_perr n%0d got %0d exp %0d", n, perr_n, exp_perr); end
      tests_run++; if (psr !== mpsr) begin tests_failed++; $display("FAIL rnd_psr n%0d got %b exp %b", n, psr, mpsr); end
      for (int r = 0; r < 8; r++) begin
        sr1 = 3'(r); sr2 = 3'(7 - r); #1;
        tests_run++; if (VSR1 !== mreg[r]) begin tests_failed++; $display("FAIL rnd_vsr1 n%0d r%0d got %h exp %h", n, r, VSR1, mreg[r]); end
        tests_run++; if (VSR2 !== mreg[7 - r]) begin tests_failed++; $display("FAIL rnd_vsr2 n%0d r%0d got %h exp %h", n, 7 - r, VSR2, mreg[7 - r]); end
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_add();
    test_load();
    test_timeout();
    test_drop();
    test_nowrite_ops();
    test_en_writeback();
    test_back_to_back();
    test_bypass();
    test_reset_midwait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
